// File: rtl/itcm_arbiter.sv
// itcm_arbiter: shares the single-port read-only ITCM between the IFU fetch
// path and LSU constant-table reads. LSU has priority, bounded by a streak
// counter so the IFU cannot starve. Each requester owns a one-entry hold
// buffer so a stalled response never blocks the other side.
module itcm_arbiter #(
  parameter int PC_SIZE        = 32,
  parameter int XLEN           = 32,
  parameter int ITCM_AW        = 12,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ifu_i_req_valid,
  output logic               ifu_o_req_ready,
  input  logic [PC_SIZE-1:0] ifu_i_req_addr,
  output logic               ifu_o_rsp_valid,
  input  logic               ifu_i_rsp_ready,
  output logic [XLEN-1:0]    ifu_o_rsp_data,
  input  logic               ifu_i_flush,
  input  logic               lsu_i_req_valid,
  output logic               lsu_o_req_ready,
  input  logic [PC_SIZE-1:0] lsu_i_req_addr,
  output logic               lsu_o_rsp_valid,
  input  logic               lsu_i_rsp_ready,
  output logic [XLEN-1:0]    lsu_o_rsp_data,
  output logic               itcm_o_enable,
  output logic [ITCM_AW-1:0] itcm_o_addr,
  input  logic [XLEN-1:0]    itcm_i_rdata
);

  localparam logic [3:0] MaxStreak = 4'(MAX_LSU_STREAK);

  logic            r_ifuInflight;
  logic            r_lsuInflight;
  logic            r_ifuHold;
  logic            r_lsuHold;
  logic [XLEN-1:0] r_ifuHoldData;
  logic [XLEN-1:0] r_lsuHoldData;
  logic [3:0]      r_streakCnt;

  logic            w_ifuElig;
  logic            w_lsuElig;
  logic            w_ifuGrant;
  logic            w_lsuGrant;
  logic            w_unusedAddrBits;

  // Byte offset and bits above the ITCM window are deliberately ignored,
  // so addresses alias modulo the ITCM size.
  assign w_unusedAddrBits = ^{ifu_i_req_addr[PC_SIZE-1:ITCM_AW+2], ifu_i_req_addr[1:0],
                              lsu_i_req_addr[PC_SIZE-1:ITCM_AW+2], lsu_i_req_addr[1:0]};

  // Eligibility and arbitration: a requester may issue only if its previous
  // response is not parked and will be consumed this cycle; LSU wins ties
  // until the streak limit forces one IFU grant.
  always_comb begin
    w_ifuElig  = ~rst & ifu_i_req_valid & ~r_ifuHold & (~r_ifuInflight | ifu_i_rsp_ready);
    w_lsuElig  = ~rst & lsu_i_req_valid & ~r_lsuHold & (~r_lsuInflight | lsu_i_rsp_ready);
    w_ifuGrant = 1'b0;
    w_lsuGrant = 1'b0;
    if (w_ifuElig && w_lsuElig) begin
      if (r_streakCnt == MaxStreak) begin
        w_ifuGrant = 1'b1;
      end else begin
        w_lsuGrant = 1'b1;
      end
    end else if (w_lsuElig) begin
      w_lsuGrant = 1'b1;
    end else if (w_ifuElig) begin
      w_ifuGrant = 1'b1;
    end
  end

  // Grant outputs and the ITCM address mux; the address idles at zero.
  always_comb begin
    ifu_o_req_ready = w_ifuGrant;
    lsu_o_req_ready = w_lsuGrant;
    itcm_o_enable   = w_ifuGrant | w_lsuGrant;
    itcm_o_addr     = '0;
    if (w_lsuGrant) begin
      itcm_o_addr = lsu_i_req_addr[ITCM_AW+1:2];
    end else if (w_ifuGrant) begin
      itcm_o_addr = ifu_i_req_addr[ITCM_AW+1:2];
    end
  end

  // Response steering: parked data takes precedence, otherwise the macro
  // output is bypassed straight through in the cycle after the grant.
  always_comb begin
    ifu_o_rsp_valid = ~ifu_i_flush & (r_ifuInflight | r_ifuHold);
    lsu_o_rsp_valid = r_lsuInflight | r_lsuHold;
    ifu_o_rsp_data  = '0;
    lsu_o_rsp_data  = '0;
    if (r_ifuHold) begin
      ifu_o_rsp_data = r_ifuHoldData;
    end else if (r_ifuInflight) begin
      ifu_o_rsp_data = itcm_i_rdata;
    end
    if (r_lsuHold) begin
      lsu_o_rsp_data = r_lsuHoldData;
    end else if (r_lsuInflight) begin
      lsu_o_rsp_data = itcm_i_rdata;
    end
  end

  // Ownership of the in-flight read: set for exactly the cycle after a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifuInflight <= 1'b0;
      r_lsuInflight <= 1'b0;
    end else begin
      r_ifuInflight <= w_ifuGrant;
      r_lsuInflight <= w_lsuGrant;
    end
  end

  // IFU hold buffer: park an unaccepted response; flush discards it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifuHold     <= 1'b0;
      r_ifuHoldData <= '0;
    end else if (ifu_i_flush) begin
      r_ifuHold <= 1'b0;
    end else if (r_ifuHold) begin
      if (ifu_i_rsp_ready) begin
        r_ifuHold <= 1'b0;
      end
    end else if (r_ifuInflight && !ifu_i_rsp_ready) begin
      r_ifuHold     <= 1'b1;
      r_ifuHoldData <= itcm_i_rdata;
    end
  end

  // LSU hold buffer: same parking behaviour, unaffected by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lsuHold     <= 1'b0;
      r_lsuHoldData <= '0;
    end else if (r_lsuHold) begin
      if (lsu_i_rsp_ready) begin
        r_lsuHold <= 1'b0;
      end
    end else if (r_lsuInflight && !lsu_i_rsp_ready) begin
      r_lsuHold     <= 1'b1;
      r_lsuHoldData <= itcm_i_rdata;
    end
  end

  // Anti-starvation streak: counts LSU wins over a waiting IFU, saturating,
  // and restarts whenever the IFU is served or stops asking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streakCnt <= '0;
    end else if (!ifu_i_req_valid || w_ifuGrant) begin
      r_streakCnt <= '0;
    end else if (w_lsuGrant && w_ifuElig && (r_streakCnt != MaxStreak)) begin
      r_streakCnt <= r_streakCnt + 4'd1;
    end
  end

endmodule

// File: doc/itcm_arbiter.md
# itcm_arbiter

Shares the single-port, read-only ITCM macro (otp4k8, 4K words) between two requesters: IFU instruction fetch and LSU data reads of constant tables held in ITCM. The block sits in ifu_top between the IFU and the ITCM macro and adds one tap for the LSU. It:
- arbitrates one access per cycle, with LSU priority and an IFU anti-starvation counter;
- tracks which requester owns the in-flight read;
- returns each response to its owner with per-requester hold buffering;
- drops stale IFU responses on pipeline flush.

## Interface
Parameters:
- PC_SIZE, 32: request address width (byte address).
- XLEN, 32: data width.
- ITCM_AW, 12: ITCM word-address width.
- MAX_LSU_STREAK, 4: maximum number of consecutive LSU grants while IFU is waiting. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifu_i_req_valid  in  1  IFU fetch request.
- ifu_o_req_ready  out  1  IFU request granted this cycle.
- ifu_i_req_addr  in  PC_SIZE  IFU byte address.
- ifu_o_rsp_valid  out  1  IFU response valid.
- ifu_i_rsp_ready  in  1  IFU accepts response.
- ifu_o_rsp_data  out  XLEN  IFU instruction word.
- ifu_i_flush  in  1  pipeline flush; drops IFU responses for grants made before this cycle.
- lsu_i_req_valid  in  1  LSU read request.
- lsu_o_req_ready  out  1  LSU request granted this cycle.
- lsu_i_req_addr  in  PC_SIZE  LSU byte address.
- lsu_o_rsp_valid  out  1  LSU response valid.
- lsu_i_rsp_ready  in  1  LSU accepts response.
- lsu_o_rsp_data  out  XLEN  LSU read word.
- itcm_o_enable  out  1  ITCM read strobe.
- itcm_o_addr  out  ITCM_AW  ITCM word address.
- itcm_i_rdata  in  XLEN  ITCM data. Valid one cycle after the strobe.

## Operation
- **Addressing:** itcm_o_addr = addr[ITCM_AW+1:2] of the granted requester.
  - Bits [1:0] are ignored.
  - Upper bits are ignored, so addresses alias modulo 16 KB.
- **Eligibility:** requester X is eligible when req_valid_X = 1, hold_X = 0, and (inflight_X = 0 or rsp_ready_X = 1).
- **Arbitration:**
  - Only LSU eligible: grant LSU.
  - Only IFU eligible: grant IFU.
  - Both eligible: grant LSU unless streak_cnt = MAX_LSU_STREAK, in which case grant IFU.
- **Streak counter (streak_cnt):**
  - Increments on each LSU grant made while IFU is eligible.
  - Clears on any IFU grant, or in any cycle IFU is not requesting.
  - Saturates at MAX_LSU_STREAK.
- **Grant outputs:** ifu_o_req_ready and lsu_o_req_ready are one-hot or zero. itcm_o_enable = OR of the two grants.
- **Idle outputs:** itcm_o_addr is combinational from the grant mux and is 0 when there is no grant.
- **In-flight tracking:** inflight_X is registered and set for exactly the cycle after a grant to X.
- **Response path:**
  - In an inflight_X cycle, rsp_valid_X = 1 and rsp_data_X = itcm_i_rdata (bypass).
  - If rsp_ready_X = 0 in that cycle, itcm_i_rdata is captured into hold_data_X and hold_X is set.
  - While hold_X = 1: rsp_valid_X = 1, rsp_data_X = hold_data_X, and X is not eligible.
  - hold_X clears on the cycle rsp_ready_X = 1.
- **Flush:** when ifu_i_flush = 1:
  - IFU inflight and hold state are dropped next edge, and ifu_o_rsp_valid is forced to 0 in the flush cycle.
  - An IFU request presented in the flush cycle is arbitrated normally, and its response is delivered.
  - LSU state is unaffected.
- **Response data:** ifu_o_rsp_data and lsu_o_rsp_data are don't-care when the corresponding rsp_valid = 0. They are driven 0 after reset.

## Timing
- **Latency:** a grant in cycle T gives rsp_valid in T+1.
- **Throughput:** back-to-back grants to the same requester are allowed when each response is accepted in its valid cycle, giving 1 access per cycle total.
- **Reset values:** all ready/valid outputs 0, itcm_o_enable 0, itcm_o_addr 0, streak_cnt 0, inflight and hold 0, response data 0.
- **Reset asserted mid-access:** the in-flight response is discarded and no rsp_valid follows reset release.
- **Simultaneous events:**
  - Flush and IFU response acceptance in the same cycle: flush wins, no handshake.
  - A held response and a new grant for the other requester proceed independently.
- **Combinational paths:** req_ready depends combinationally on rsp_ready of the same requester. There is no path from itcm_i_rdata to any ready output.

## Test plan
- **Single IFU fetch:** ifu addr 0x0000_0010, rsp_ready = 1.
  - itcm_o_addr = 4 with enable in T.
  - ifu_o_rsp_valid in T+1 with itcm word 4.
  - No LSU activity.
- **Simultaneous requests with streak limit:** both requesting continuously, MAX_LSU_STREAK = 4.
  - Grant pattern is LSU×4, IFU, LSU×4, IFU.
  - Responses are routed to their owners with the correct words.
- **Backpressure:** IFU rsp_ready = 0 for 3 cycles after a grant on addr 0x8.
  - ifu_o_rsp_valid stays 1 with word 2 for 4 cycles.
  - No new IFU grant occurs while held.
  - LSU is still granted in those cycles.
- **Flush:** flush asserted the cycle after an IFU grant.
  - No IFU rsp_valid for the old grant.
  - An IFU request in the flush cycle at 0x100 returns word 64 at T+1.
- **Reset mid-access:** rst pulsed while an LSU response is held.
  - All outputs go to 0 immediately.
  - No response after release.
  - The first post-reset grant behaves as in the single-fetch case.
- **Address aliasing:** LSU addr 0x0000_4004 reads ITCM word 1, the same as addr 0x4.
